// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM state type, default float field widths and float constants.
package cnn_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
   localparam int FP_DW = 32;
   localparam int FP_EW = 8;
   localparam logic [FP_DW-1:0] FP_QNAN = 32'h7FC0_0000;
   localparam logic [FP_DW-1:0] FP_ZERO = 32'h0000_0000;
endpackage

// File: rtl/fp_greater.sv
// fp_greater: combinational a > b for IEEE-style floats; NaN on a never wins, NaN on b always loses.
module fp_greater import cnn_pkg::*; #(
   parameter int DATAWIDTH = FP_DW,
   parameter int EXPWIDTH  = FP_EW
) (
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] b,
   output logic                 gt
);
   localparam int MW = DATAWIDTH - 1 - EXPWIDTH;
   logic nan_a, nan_b, zero_both;
   logic [DATAWIDTH-1:0] ka, kb;
   always_comb begin
      nan_a = (&a[DATAWIDTH-2 -: EXPWIDTH]) && (|a[MW-1:0]);
      nan_b = (&b[DATAWIDTH-2 -: EXPWIDTH]) && (|b[MW-1:0]);
      // Sign-magnitude to monotonic unsigned key: negatives below positives, magnitude reversed.
      ka = a[DATAWIDTH-1] ? {1'b0, ~a[DATAWIDTH-2:0]} : {1'b1, a[DATAWIDTH-2:0]};
      kb = b[DATAWIDTH-1] ? {1'b0, ~b[DATAWIDTH-2:0]} : {1'b1, b[DATAWIDTH-2:0]};
      zero_both = ~|a[DATAWIDTH-2:0] && ~|b[DATAWIDTH-2:0];
      gt = !nan_a && (nan_b || (!zero_both && ka > kb));
   end
endmodule

// File: rtl/argmax_stream.sv
// argmax_stream: streaming argmax over NUM_CLASSES float elements per vector,
// with length-error flag and a held result handshake.
module argmax_stream import cnn_pkg::*; #(
   parameter int DATAWIDTH   = FP_DW,
   parameter int EXPWIDTH    = FP_EW,
   parameter int NUM_CLASSES = 10,
   parameter int IDXWIDTH    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] in_data,
   input  logic                 in_last,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out_max,
   output logic [IDXWIDTH-1:0]  out_index,
   output logic                 out_len_err
);
   localparam int CW = $clog2(NUM_CLASSES + 1);
   state_t state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic accept, done, gt, full;
   fp_greater #(.DATAWIDTH(DATAWIDTH), .EXPWIDTH(EXPWIDTH)) u_cmp (
      .a  (in_data),
      .b  (out_max),
      .gt (gt)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   always_comb begin
      in_ready   = state != HOLD;
      out_valid  = state == HOLD;
      accept     = in_valid && in_ready;
      cnt_next   = (state == IDLE) ? CW'(1) : (cnt == CW'(NUM_CLASSES)) ? cnt : cnt + 1'b1;
      full       = cnt_next == CW'(NUM_CLASSES);
      done       = accept && (in_last || full);
      state_next = out_valid ? (out_ready ? IDLE : HOLD) : done ? HOLD : accept ? ACCUM : state;
   end
   // In ACCUM the counter equals the zero-based index of the incoming element.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt         <= '0;
         out_max     <= '0;
         out_index   <= '0;
         out_len_err <= 1'b0;
      end else if (accept) begin
         cnt <= cnt_next;
         if (state == IDLE || gt) begin
            out_max   <= in_data;
            out_index <= (state == IDLE) ? '0 : IDXWIDTH'(cnt);
         end
         if (done) out_len_err <= in_last ^ full;
      end
endmodule

// File: tb/tb_argmax_stream.sv
// tb_argmax_stream: directed vectors with hand-computed argmax results.
module tb_argmax_stream;
   import cnn_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic in_ready, out_valid, out_len_err;
   logic [31:0] out_max;
   logic [3:0] out_index;
   int n_chk = 0, n_pass = 0;

   argmax_stream dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
      .out_max(out_max), .out_index(out_index), .out_len_err(out_len_err)
   );

   always #5 clk = ~clk;

   logic [31:0] v1 [10] = '{32'h3F800000, 32'h40600000, 32'h40000000, 32'h40600000, 32'h3F000000,
                            32'h3DCCCCCD, 32'h3E4CCCCD, 32'h3E99999A, 32'h3ECCCCCD, 32'h3F19999A};
   logic [31:0] v2 [10] = '{32'hC0A00000, 32'hBF800000, 32'hC0400000, 32'hC0000000, 32'hC0000000,
                            32'hC0000000, 32'hC0000000, 32'hC0000000, 32'hC0000000, 32'hC0000000};
   logic [31:0] v3 [10] = '{FP_QNAN, 32'h80000000, FP_ZERO, 32'hBF800000, 32'hBF800000,
                            32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000, 32'hBF800000};
   logic [31:0] v4 [10] = '{32'h3F800000, 32'h40000000, 32'h40A00000, 32'h40400000, 32'h0,
                            32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
   logic [31:0] v5 [10] = '{32'hFF800000, 32'hFF800000, 32'hC0000000, 32'h7F800000, 32'h3F800000,
                            32'h7F800000, 32'hFF800000, 32'h0, 32'h7FC00000, 32'hFF800000};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic send_vec(input logic [31:0] v [10], input int n, input bit last);
      for (int i = 0; i < n; i++) begin
         check("in_ready", 32'(in_ready), 32'h1);
         in_data  = v[i];
         in_last  = last && (i == n - 1);
         in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         in_last  = 1'b0;
         if (i < n - 1) check("early_valid", 32'(out_valid), 32'h0);
      end
   endtask

   task automatic take(input logic [31:0] emax, input logic [31:0] eidx, input logic [31:0] eerr);
      check("out_valid", 32'(out_valid), 32'h1);
      check("out_max", out_max, emax);
      check("out_index", 32'(out_index), eidx);
      check("out_len_err", 32'(out_len_err), eerr);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("released", 32'(out_valid), 32'h0);
      check("ready_again", 32'(in_ready), 32'h1);
   endtask

   initial begin
      #3;
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_ready", 32'(in_ready), 32'h1);
      check("rst_max", out_max, 32'h0);
      check("rst_index", 32'(out_index), 32'h0);
      check("rst_err", 32'(out_len_err), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      send_vec(v1, 10, 1'b1);
      take(32'h40600000, 1, 0);
      send_vec(v2, 10, 1'b1);
      take(32'hBF800000, 1, 0);
      send_vec(v3, 10, 1'b1);
      take(32'h80000000, 1, 0);
      send_vec(v4, 4, 1'b1);
      take(32'h40A00000, 2, 1);
      send_vec(v1, 10, 1'b0);
      take(32'h40600000, 1, 1);
      send_vec(v2, 10, 1'b1);
      in_valid = 1'b1;
      in_data  = 32'h7F800000;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(out_valid), 32'h1);
         check("hold_ready", 32'(in_ready), 32'h0);
         check("hold_max", out_max, 32'hBF800000);
         check("hold_index", 32'(out_index), 32'h1);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      take(32'hBF800000, 1, 0);
      send_vec(v5, 10, 1'b1);
      take(32'h7F800000, 3, 0);
      send_vec(v1, 6, 1'b0);
      rst_n = 1'b0;
      #2;
      check("mid_rst_valid", 32'(out_valid), 32'h0);
      check("mid_rst_ready", 32'(in_ready), 32'h1);
      check("mid_rst_max", out_max, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      send_vec(v2, 10, 1'b1);
      take(32'hBF800000, 1, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/argmax_stream.md
ARGMAX_STREAM -- requirements
Module: argmax_stream

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 32, meaning total float width (sign, exponent, mantissa).
REQ-002 The block SHALL have parameter EXPWIDTH, default 8, meaning exponent field width; mantissa width = DATAWIDTH-1-EXPWIDTH.
REQ-003 The block SHALL have parameter NUM_CLASSES, default 10, meaning elements per vector (2..65535).
REQ-004 The block SHALL have parameter IDXWIDTH, default 4, meaning index width; IDXWIDTH >= clog2(NUM_CLASSES).
REQ-005 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit, meaning in_data and in_last are valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts an element this cycle.
REQ-009 The block SHALL have port in_data, input, DATAWIDTH bits, meaning one IEEE-style float element.
REQ-010 The block SHALL have port in_last, input, 1 bit, meaning the element is the final element of its vector.
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning a result is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-013 The block SHALL have ports out_max (DATAWIDTH bits) and out_index (IDXWIDTH bits), both outputs, meaning the maximum value and its zero-based position.
REQ-014 The block SHALL have port out_len_err, output, 1 bit, meaning the vector length differed from NUM_CLASSES.

Function
REQ-015 An element SHALL transfer when in_valid and in_ready are both high; the result SHALL transfer when out_valid and out_ready are both high.
REQ-016 The FSM SHALL have states IDLE, ACCUM and HOLD; in_ready = 1 in IDLE and ACCUM, 0 in HOLD; out_valid = 1 only in HOLD.
REQ-017 In IDLE, an accepted element SHALL load best value and best index = 0, and set the element counter to 1.
REQ-018 After an IDLE load, the FSM SHALL go to HOLD if that element ended the vector, else to ACCUM.
REQ-019 In ACCUM, each accepted element SHALL be compared against the best value.
REQ-020 The best value and index SHALL be replaced only when the new element is strictly greater.
REQ-021 On equal values the earliest index SHALL win.
REQ-022 Comparison SHALL be a full signed float compare, ordered by sign, then exponent, then mantissa, with magnitude order reversed for negatives.
REQ-023 +0 and -0 SHALL compare equal.
REQ-024 A NaN element (exponent all ones, mantissa nonzero) SHALL never replace the best value.
REQ-025 A NaN first element SHALL be replaced by any later non-NaN element.
REQ-026 +Inf and -Inf SHALL be ordered normally.
REQ-027 The vector SHALL end on an accepted element with in_last = 1, or on the NUM_CLASSES-th accepted element, whichever comes first; the FSM then enters HOLD on the next edge.
REQ-028 out_len_err SHALL be 1 if the vector ended with in_last = 1 before NUM_CLASSES elements were accepted.
REQ-029 out_len_err SHALL be 1 if the vector ended on the NUM_CLASSES-th element without in_last = 1; otherwise it SHALL be 0.
REQ-030 Latency SHALL be exactly 1 cycle from the edge accepting the final element to out_valid = 1.
REQ-031 In HOLD, out_max, out_index and out_len_err SHALL stay stable until the result transfers; the FSM then returns to IDLE.
REQ-032 No element SHALL be accepted in the cycle the result transfers, so throughput is NUM_CLASSES+1 cycles per vector at best.
REQ-033 The element counter SHALL saturate at NUM_CLASSES and SHALL NOT wrap.
REQ-034 in_valid gaps SHALL stall accumulation without changing state.

Reset
REQ-035 While rst_n = 0, the block SHALL asynchronously set state = IDLE, counter = 0, out_max = 0, out_index = 0, out_len_err = 0 and out_valid = 0; in_ready SHALL then be 1.
REQ-036 Reset asserted mid-vector or in HOLD SHALL discard the partial vector or pending result without emitting it.
REQ-037 Release of reset SHALL be synchronised externally; the block SHALL accept input starting the first edge after release.

Structure
REQ-038 The shared package cnn_pkg SHALL hold the FSM state enum, the default float field widths, and the canonical NaN and zero constants.
REQ-039 The compare SHALL be a combinational sub-module fp_greater(a, b, gt) reused by the FSM; gt excludes NaN on a and treats b = NaN as the smaller value.

Verification
REQ-040 Scenario: stream 1.0, 3.5, 2.0, 3.5, 0.5, 0.1, 0.2, 0.3, 0.4, 0.6 with last on element 10 -> out_max = 0x40600000, out_index = 1, out_len_err = 0, out_valid one cycle after element 10.
REQ-041 Scenario: stream -5.0, -1.0, -3.0, then seven values of -2.0 -> out_max = 0xBF800000, out_index = 1.
REQ-042 Scenario: stream NaN 0x7FC00000, then -0.0, +0.0, and 7 values of -1.0 -> out_max = 0x80000000, out_index = 1.
REQ-043 Scenario: in_last on element 4 -> out_valid with out_len_err = 1; 10 elements without last -> out_len_err = 1.
REQ-044 Scenario: hold out_ready = 0 for 5 cycles in HOLD while driving in_valid = 1 -> outputs stable, in_ready = 0, no element consumed.
REQ-045 Scenario: assert rst_n = 0 after element 6 -> out_valid = 0 and in_ready = 1 immediately; the next full vector produces the correct independent result.
